// File: rtl/perf_counter_bank.sv
// Bank of independent event counters with sticky overflow, per-channel clear/load,
// a snapshot copy into shadow registers, and a single muxed readout port.
// Latency: o_rd_value is registered, 1 cycle after i_rd_sel/i_rd_snap are sampled.
// Backpressure: none; every strobe is acted on at the edge it is sampled.
//
// Ports:
//   i_clock, i_reset      single clock, synchronous active-high reset
//   i_enable              global increment gate (does not affect clear/load/snapshot/read)
//   i_event[CHANNELS]     per-channel increment strobes
//   i_clear[CHANNELS]     per-channel clear (count and overflow)
//   i_load, i_load_sel,   write i_load_value into one channel; out-of-range select ignored
//   i_load_value
//   i_snapshot            copy every live count into its shadow register
//   i_rd_sel, i_rd_snap   readout select (live or shadow); out-of-range select reads 0
//   o_rd_value            registered readout
//   o_overflow            sticky per-channel overflow flags
module perf_counter_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [CHANNELS-1:0] i_event,
    input  logic [CHANNELS-1:0] i_clear,
    input  logic                i_load,
    input  logic [SEL_W-1:0]    i_load_sel,
    input  logic [WIDTH-1:0]    i_load_value,
    input  logic                i_snapshot,
    input  logic [SEL_W-1:0]    i_rd_sel,
    input  logic                i_rd_snap,
    output logic [WIDTH-1:0]    o_rd_value,
    output logic [CHANNELS-1:0] o_overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0]    r_count  [CHANNELS];
    logic [WIDTH-1:0]    r_shadow [CHANNELS];
    logic [CHANNELS-1:0] r_overflow;
    logic [WIDTH-1:0]    r_rd_value;
    logic [WIDTH-1:0]    w_rd_mux;

    // Readout mux built as a compare per channel, so a select beyond the last
    // channel (non power-of-two bank) falls through to the zero default.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_rd_sel == SEL_W'(i)) begin
                w_rd_mux = i_rd_snap ? r_shadow[i] : r_count[i];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_count[i]  <= '0;
                r_shadow[i] <= '0;
            end
            r_overflow <= '0;
            r_rd_value <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // Shadow takes the pre-edge count, independent of what the
                // channel itself does this cycle.
                if (i_snapshot) begin
                    r_shadow[i] <= r_count[i];
                end

                if (i_clear[i]) begin
                    r_count[i]    <= '0;
                    r_overflow[i] <= 1'b0;
                end else if (i_load && (i_load_sel == SEL_W'(i))) begin
                    r_count[i]    <= i_load_value;
                    r_overflow[i] <= 1'b0;
                end else if (i_enable && i_event[i]) begin
                    if (r_count[i] == CNT_MAX) begin
                        r_overflow[i] <= 1'b1;
                        r_count[i]    <= (SATURATE != 0) ? CNT_MAX : '0;
                    end else begin
                        r_count[i] <= r_count[i] + WIDTH'(1);
                    end
                end
            end
            r_rd_value <= w_rd_mux;
        end
    end

    assign o_rd_value = r_rd_value;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: three instances (wrap, saturate,
// three-channel) share one stimulus stream; reads push hand-computed
// expectations, a negedge monitor pops and compares when the read lands.
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  event_v = '0;
    logic [3:0]  clear_v = '0;
    logic        load = 1'b0;
    logic [1:0]  load_sel = '0;
    logic [15:0] load_value = '0;
    logic        snapshot = 1'b0;
    logic [1:0]  rd_sel = '0;
    logic        rd_snap = 1'b0;

    logic [15:0] rd0, rds, rd3;
    logic [3:0]  ov0, ovs;
    logic [2:0]  ov3;

    always #5 clk = ~clk;

    perf_counter_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(0)) dut0 (
        .i_clock(clk), .i_reset(reset), .i_enable(enable), .i_event(event_v),
        .i_clear(clear_v), .i_load(load), .i_load_sel(load_sel), .i_load_value(load_value),
        .i_snapshot(snapshot), .i_rd_sel(rd_sel), .i_rd_snap(rd_snap),
        .o_rd_value(rd0), .o_overflow(ov0));

    perf_counter_bank #(.WIDTH(16), .CHANNELS(4), .SATURATE(1)) dut_sat (
        .i_clock(clk), .i_reset(reset), .i_enable(enable), .i_event(event_v),
        .i_clear(clear_v), .i_load(load), .i_load_sel(load_sel), .i_load_value(load_value),
        .i_snapshot(snapshot), .i_rd_sel(rd_sel), .i_rd_snap(rd_snap),
        .o_rd_value(rds), .o_overflow(ovs));

    perf_counter_bank #(.WIDTH(16), .CHANNELS(3), .SATURATE(0)) dut3 (
        .i_clock(clk), .i_reset(reset), .i_enable(enable), .i_event(event_v[2:0]),
        .i_clear(clear_v[2:0]), .i_load(load), .i_load_sel(load_sel), .i_load_value(load_value),
        .i_snapshot(snapshot), .i_rd_sel(rd_sel), .i_rd_snap(rd_snap),
        .o_rd_value(rd3), .o_overflow(ov3));

    typedef struct {
        int          id;
        int          dut;
        logic [15:0] rd;
        logic [3:0]  ovf;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   next_id = 0;
    bit   rd_req = 1'b0;
    int   rd_id = 0;
    bit   rd_vld_d = 1'b0;
    int   rd_id_d = 0;

    always @(posedge clk) begin
        rd_vld_d <= rd_req;
        rd_id_d  <= rd_id;
    end

    // Monitor: the read requested before edge N is visible after edge N.
    always @(negedge clk) begin
        exp_t        it;
        logic [15:0] a_rd;
        logic [3:0]  a_ov;
        int          got;
        if (rd_vld_d) begin
            got = 0;
            while (sb_q.size() != 0 && sb_q[0].id == rd_id_d) begin
                it = sb_q.pop_front();
                got++;
                case (it.dut)
                    0:       begin a_rd = rd0; a_ov = ov0; end
                    1:       begin a_rd = rds; a_ov = ovs; end
                    default: begin a_rd = rd3; a_ov = {1'b0, ov3}; end
                endcase
                checks++;
                if (a_rd !== it.rd) begin
                    failures++;
                    $display("FAIL %s dut%0d rd_value got=%h exp=%h", it.name, it.dut, a_rd, it.rd);
                end
                checks++;
                if (a_ov !== it.ovf) begin
                    failures++;
                    $display("FAIL %s dut%0d overflow got=%b exp=%b", it.name, it.dut, a_ov, it.ovf);
                end
            end
            checks++;
            if (got != 3) begin
                failures++;
                $display("FAIL read_id%0d expectations popped got=%0d exp=3", rd_id_d, got);
            end
        end
    end

    // Advance one edge, then drop all single-cycle strobes.
    task automatic go();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        enable   = 1'b0;
        event_v  = '0;
        clear_v  = '0;
        load     = 1'b0;
        snapshot = 1'b0;
        rd_req   = 1'b0;
    endtask

    // Issue a read this cycle; e0/es/e3 are the expected values for the
    // wrap, saturate and three-channel instances, ov the post-edge flags.
    task automatic rd(input logic [1:0] sel, input logic snap, input string nm,
                      input logic [15:0] e0, input logic [15:0] es, input logic [15:0] e3,
                      input logic [3:0] ov);
        rd_sel  = sel;
        rd_snap = snap;
        rd_req  = 1'b1;
        rd_id   = next_id;
        sb_q.push_back('{next_id, 0, e0, ov, nm});
        sb_q.push_back('{next_id, 1, es, ov, nm});
        sb_q.push_back('{next_id, 2, e3, {1'b0, ov[2:0]}, nm});
        next_id++;
        go();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        rd(0, 0, "rst_c0", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(3, 1, "rst_s3", 16'd0, 16'd0, 16'd0, 4'b0000);

        // Ten events on channel 0, reading it each cycle (pre-edge value).
        for (int k = 0; k < 10; k++) begin
            enable  = 1'b1;
            event_v = 4'b0001;
            rd(0, 0, "cnt_c0", 16'(k), 16'(k), 16'(k), 4'b0000);
        end
        rd(0, 0, "cnt10_c0", 16'd10, 16'd10, 16'd10, 4'b0000);
        rd(1, 0, "cnt_c1", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(2, 0, "cnt_c2", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(3, 0, "cnt_c3", 16'd0, 16'd0, 16'd0, 4'b0000);

        // Wrap vs saturate on channel 1.
        load = 1'b1; load_sel = 2'd1; load_value = 16'hFFFE; go();
        for (int k = 0; k < 3; k++) begin
            enable = 1'b1; event_v = 4'b0010; go();
        end
        rd(1, 0, "wrap_c1", 16'h0001, 16'hFFFF, 16'h0001, 4'b0010);
        enable = 1'b1; event_v = 4'b0011; go();
        rd(1, 0, "sticky_c1", 16'h0002, 16'hFFFF, 16'h0002, 4'b0010);
        rd(0, 0, "c0_11", 16'd11, 16'd11, 16'd11, 4'b0010);

        // enable=0 blocks events but not clear.
        enable = 1'b0; event_v = 4'b1111; go();
        rd(0, 0, "en0_c0", 16'd11, 16'd11, 16'd11, 4'b0010);
        clear_v = 4'b0001; go();
        rd(0, 0, "clr_c0", 16'd0, 16'd0, 16'd0, 4'b0010);
        clear_v = 4'b0010; go();
        rd(1, 0, "clrovf_c1", 16'd0, 16'd0, 16'd0, 4'b0000);

        // Overflow on channel 2, then load clears it; priority clear > load > inc.
        load = 1'b1; load_sel = 2'd2; load_value = 16'hFFFF; go();
        enable = 1'b1; event_v = 4'b0100; go();
        rd(2, 0, "wrap_c2", 16'h0000, 16'hFFFF, 16'h0000, 4'b0100);
        load = 1'b1; load_sel = 2'd2; load_value = 16'd5; go();
        rd(2, 0, "ld_c2", 16'd5, 16'd5, 16'd5, 4'b0000);
        enable = 1'b1; clear_v = 4'b0100; load = 1'b1; load_sel = 2'd2;
        load_value = 16'd9; event_v = 4'b0100; go();
        rd(2, 0, "prio_clr", 16'd0, 16'd0, 16'd0, 4'b0000);
        enable = 1'b1; load = 1'b1; load_sel = 2'd2; load_value = 16'd9; event_v = 4'b0100; go();
        rd(2, 0, "prio_ld", 16'd9, 16'd9, 16'd9, 4'b0000);

        // Channel 3 load (ignored by the three-channel bank), then snapshot.
        enable = 1'b1; load = 1'b1; load_sel = 2'd3; load_value = 16'd7; event_v = 4'b1000; go();
        rd(3, 0, "ld_c3", 16'd7, 16'd7, 16'd0, 4'b0000);
        rd(2, 0, "sel3_c2", 16'd9, 16'd9, 16'd9, 4'b0000);
        snapshot = 1'b1; enable = 1'b1; event_v = 4'b1000; go();
        for (int k = 0; k < 4; k++) begin
            enable = 1'b1; event_v = 4'b1000; go();
        end
        rd(3, 1, "snap_s3", 16'd7, 16'd7, 16'd0, 4'b0000);
        rd(3, 0, "live_c3", 16'd12, 16'd12, 16'd0, 4'b0000);
        rd(2, 1, "snap_s2", 16'd9, 16'd9, 16'd9, 4'b0000);
        snapshot = 1'b1; clear_v = 4'b0100; go();
        rd(2, 1, "snapclr_s2", 16'd9, 16'd9, 16'd9, 4'b0000);
        rd(2, 0, "snapclr_c2", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(3, 1, "snapclr_s3", 16'd12, 16'd12, 16'd0, 4'b0000);

        // All channels count in the same cycle.
        enable = 1'b1; event_v = 4'b1111; go();
        rd(0, 0, "all_c0", 16'd1, 16'd1, 16'd1, 4'b0000);
        rd(1, 0, "all_c1", 16'd1, 16'd1, 16'd1, 4'b0000);
        rd(2, 0, "all_c2", 16'd1, 16'd1, 16'd1, 4'b0000);
        rd(3, 0, "all_c3", 16'd13, 16'd13, 16'd0, 4'b0000);

        // Reset overrides everything, including a same-cycle read.
        load = 1'b1; load_sel = 2'd0; load_value = 16'hFFFF; go();
        enable = 1'b1; event_v = 4'b0001; go();
        rd(0, 0, "pre_rst", 16'h0000, 16'hFFFF, 16'h0000, 4'b0001);
        reset = 1'b1; enable = 1'b1; event_v = 4'b1111; load = 1'b1; load_sel = 2'd1;
        load_value = 16'hAAAA; snapshot = 1'b1;
        rd(3, 0, "rst_rd", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(3, 0, "post_c3", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(3, 1, "post_s3", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(1, 0, "post_c1", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(1, 1, "post_s1", 16'd0, 16'd0, 16'd0, 4'b0000);
        rd(0, 1, "post_s0", 16'd0, 16'd0, 16'd0, 4'b0000);

        go();
        go();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain leftover got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
